// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Op codes follow the funct3 field of the M-extension encodings.
package mdu_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 5;

   localparam logic [2:0] MUL    = 3'd0;
   localparam logic [2:0] MULH   = 3'd1;
   localparam logic [2:0] MULHSU = 3'd2;
   localparam logic [2:0] MULHU  = 3'd3;
   localparam logic [2:0] DIV    = 3'd4;
   localparam logic [2:0] DIVU   = 3'd5;
   localparam logic [2:0] REM    = 3'd6;
   localparam logic [2:0] REMU   = 3'd7;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      CALC = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the shared datapath: shift-add for multiply,
// compare-subtract-shift (restoring) for divide.
module mdu_iter_step
   import mdu_pkg::*;
(
   input  logic                is_div,
   input  logic [2*XLEN-1:0]   acc_i,
   input  logic [XLEN-1:0]     opnd_i,
   output logic [2*XLEN-1:0]   acc_o
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem_sh;
   logic [XLEN-1:0] diff;
   logic            ge;

   // Multiply keeps {hi, multiplier} and shifts right; divide keeps
   // {remainder, quotient} and shifts left, inserting the quotient bit.
   always_comb begin
      sum    = {1'b0, acc_i[2*XLEN-1:XLEN]}
             + (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
      rem_sh = acc_i[2*XLEN-1:XLEN-1];
      ge     = (rem_sh >= {1'b0, opnd_i});
      diff   = rem_sh[XLEN-1:0] - opnd_i;
      if (is_div) begin
         if (ge) acc_o = {diff, acc_i[XLEN-2:0], 1'b1};
         else    acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
         acc_o = {sum, acc_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit with fixed latency,
// a single-cycle done pulse and a synchronous kill for flushes.
module mul_div_unit
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic [4:0]  rd_in,
   input  logic        kill,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  rd_out
);

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [4:0]        rd_q, rd_d;
   logic              neg_q, neg_d;
   logic              rneg_q, rneg_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic [4:0]        rdo_q, rdo_d;

   logic              a_neg, b_neg;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic [2*XLEN-1:0] acc_step;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem;
   logic              div0, ovf;
   logic [XLEN-1:0]   fix_res;

   mdu_iter_step u_step (
      .is_div (op_q[2]),
      .acc_i  (acc_q),
      .opnd_i (opnd_q),
      .acc_o  (acc_step)
   );

   // Operand signedness per op and magnitudes fed to the iteration.
   always_comb begin
      a_neg = a_q[XLEN-1]
            & ((op_q == MUL) | (op_q == MULH) | (op_q == MULHSU)
            |  (op_q == DIV) | (op_q == REM));
      b_neg = b_q[XLEN-1]
            & ((op_q == MUL) | (op_q == MULH)
            |  (op_q == DIV) | (op_q == REM));
      abs_a = a_neg ? -a_q : a_q;
      abs_b = b_neg ? -b_q : b_q;
   end

   // Sign fix-up, special-case override and output selection.
   always_comb begin
      prod    = neg_q ? -acc_q : acc_q;
      quo     = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem     = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      div0    = (b_q == '0);
      ovf     = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
      fix_res = '0;
      case (op_q)
         MUL:    fix_res = prod[XLEN-1:0];
         MULH,
         MULHSU,
         MULHU:  fix_res = prod[2*XLEN-1:XLEN];
         DIV:    fix_res = div0 ? {XLEN{1'b1}}
                         : ovf  ? 32'h8000_0000 : quo;
         DIVU:   fix_res = div0 ? {XLEN{1'b1}} : acc_q[XLEN-1:0];
         REM:    fix_res = div0 ? a_q : ovf ? '0 : rem;
         REMU:   fix_res = div0 ? a_q : acc_q[2*XLEN-1:XLEN];
         default: fix_res = '0;
      endcase
   end

   // Sequencer: next state, datapath loads and kill handling.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      rd_d    = rd_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      rdo_d   = rdo_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !kill) begin
               op_d    = funct3;
               a_d     = rs1_val;
               b_d     = rs2_val;
               rd_d    = rd_in;
               state_d = PREP;
            end
         end
         PREP: begin
            acc_d   = {{XLEN{1'b0}}, abs_a};
            opnd_d  = abs_b;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            cnt_d   = '0;
            state_d = CALC;
         end
         CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN-1)) state_d = FIX;
         end
         FIX: begin
            res_d   = fix_res;
            rdo_d   = rd_q;
            state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (kill && (state_q != IDLE)) begin
         state_d = IDLE;
         done_d  = 1'b0;
         res_d   = res_q;
         rdo_d   = rdo_q;
      end
      busy_d = (state_d != IDLE);
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rd_q    <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         acc_q   <= '0;
         opnd_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= '0;
         rdo_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rd_q    <= rd_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         res_q   <= res_d;
         rdo_q   <= rdo_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = res_q;
   assign rd_out = rdo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus
// hand-written ignore/kill/reset sequences.
module tb_mul_div_unit;

   localparam logic [2:0] F_MUL    = 3'd0;
   localparam logic [2:0] F_MULH   = 3'd1;
   localparam logic [2:0] F_MULHSU = 3'd2;
   localparam logic [2:0] F_MULHU  = 3'd3;
   localparam logic [2:0] F_DIV    = 3'd4;
   localparam logic [2:0] F_DIVU   = 3'd5;
   localparam logic [2:0] F_REM    = 3'd6;
   localparam logic [2:0] F_REMU   = 3'd7;
   localparam int         LAT      = 35;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [4:0]  rd_in;
   logic        kill;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int n_cmp;
   int n_err;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[18];

   mul_div_unit dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .funct3  (funct3),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .rd_in   (rd_in),
      .kill    (kill),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .rd_out  (rd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   // Starts one op at the current cycle; inj >= 0 pulses a junk
   // start that many edges after the accepting edge.
   task automatic run_op(input string nm, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp,
                         input int inj);
      int n;
      int bad_busy;
      start   = 1'b1;
      funct3  = f;
      rs1_val = a;
      rs2_val = b;
      rd_in   = rd;
      @(posedge clk); #1;
      start   = 1'b0;
      rs1_val = 32'h1234_5678;
      rs2_val = 32'h0000_0003;
      rd_in   = 5'd30;
      funct3  = F_MUL;
      n = 0;
      bad_busy = 0;
      while (!done && n < LAT + 5) begin
         if (n == inj) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         n++;
         if (!done && !busy) bad_busy++;
      end
      chk({nm, " latency"}, 32'(n), 32'(LAT));
      chk({nm, " busy_span"}, 32'(bad_busy), 32'd0);
      chk({nm, " busy_at_done"}, {31'd0, busy}, 32'd0);
      chk({nm, " result"}, result, exp);
      chk({nm, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
      @(posedge clk); #1;
      chk({nm, " done_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst     = 1'b0;
      start   = 1'b0;
      kill    = 1'b0;
      funct3  = '0;
      rs1_val = '0;
      rs2_val = '0;
      rd_in   = '0;

      tbl[0]  = '{F_MUL,    32'd7,         32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB};
      tbl[1]  = '{F_MULH,   32'h80000000,  32'h80000000, 5'd1,  32'h40000000};
      tbl[2]  = '{F_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE};
      tbl[3]  = '{F_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF};
      tbl[4]  = '{F_DIV,    32'hFFFFFFF9,  32'd2,        5'd4,  32'hFFFFFFFD};
      tbl[5]  = '{F_REM,    32'hFFFFFFF9,  32'd2,        5'd6,  32'hFFFFFFFF};
      tbl[6]  = '{F_DIVU,   32'd100,       32'd7,        5'd7,  32'd14};
      tbl[7]  = '{F_REMU,   32'd100,       32'd7,        5'd8,  32'd2};
      tbl[8]  = '{F_DIV,    32'd5,         32'd0,        5'd9,  32'hFFFFFFFF};
      tbl[9]  = '{F_REMU,   32'd5,         32'd0,        5'd10, 32'd5};
      tbl[10] = '{F_DIV,    32'h80000000,  32'hFFFFFFFF, 5'd11, 32'h80000000};
      tbl[11] = '{F_REM,    32'h80000000,  32'hFFFFFFFF, 5'd12, 32'd0};
      tbl[12] = '{F_REM,    32'd7,         32'hFFFFFFFE, 5'd13, 32'd1};
      tbl[13] = '{F_DIV,    32'd7,         32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD};
      tbl[14] = '{F_MULH,   32'hFFFFFFFF,  32'd1,        5'd15, 32'hFFFFFFFF};
      tbl[15] = '{F_MUL,    32'h00010000,  32'h00010000, 5'd0,  32'd0};
      tbl[16] = '{F_MULHU,  32'h00010000,  32'h00010000, 5'd16, 32'd1};
      tbl[17] = '{F_DIVU,   32'hFFFFFFFF,  32'd1,        5'd17, 32'hFFFFFFFF};

      #2;
      chk("reset busy",   {31'd0, busy}, 32'd0);
      chk("reset done",   {31'd0, done}, 32'd0);
      chk("reset result", result, 32'd0);
      chk("reset rd_out", {27'd0, rd_out}, 32'd0);
      #10;
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 18; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a,
                tbl[i].b, tbl[i].rd, tbl[i].exp, -1);
      end

      // Second start during a MUL is ignored.
      run_op("ignore", F_MUL, 32'd7, 32'hFFFFFFFD, 5'd5,
             32'hFFFFFFEB, 9);
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) break;
      end
      chk("ignore no_second_op", {30'd0, busy, done}, 32'd0);

      // kill and start together in IDLE: start dropped.
      start = 1'b1;
      kill  = 1'b1;
      funct3 = F_DIVU;
      @(posedge clk); #1;
      start = 1'b0;
      kill  = 1'b0;
      chk("idle kill busy", {31'd0, busy}, 32'd0);

      // kill in CALC: back to IDLE, outputs held.
      start   = 1'b1;
      funct3  = F_DIVU;
      rs1_val = 32'd100;
      rs2_val = 32'd7;
      rd_in   = 5'd21;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
      end
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      chk("kill busy",   {31'd0, busy}, 32'd0);
      chk("kill done",   {31'd0, done}, 32'd0);
      chk("kill result", result, 32'hFFFFFFEB);
      chk("kill rd_out", {27'd0, rd_out}, 32'd5);
      run_op("after_kill", F_REMU, 32'd100, 32'd7, 5'd22, 32'd2, -1);

      // Asynchronous reset mid-CALC.
      start   = 1'b1;
      funct3  = F_MUL;
      rs1_val = 32'd3;
      rs2_val = 32'd4;
      rd_in   = 5'd23;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
      end
      #2;
      rst = 1'b0;
      #1;
      chk("arst busy",   {31'd0, busy}, 32'd0);
      chk("arst done",   {31'd0, done}, 32'd0);
      chk("arst result", result, 32'd0);
      chk("arst rd_out", {27'd0, rd_out}, 32'd0);
      #3;
      rst = 1'b1;
      @(posedge clk); #1;
      run_op("post_rst", F_DIVU, 32'd9, 32'd3, 5'd24, 32'd3, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
